// File: rtl/pipe_stage_mw.sv
// M-to-W pipeline stage: two-entry skid buffer with registered ready,
// idle-value outputs when empty, x0 write suppression and a retire counter.
module pipe_stage_mw #(
    parameter int              XLEN     = 32,
    parameter int              REG_AW   = 5,
    parameter int              CNT_W    = 32,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              m_valid_i,
    output logic              m_ready_o,
    input  logic [REG_AW-1:0] rdaddr_M_i,
    input  logic              rdwr_M_i,
    input  logic [XLEN-1:0]   datareg_M_i,
    input  logic [XLEN-1:0]   inst_M_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [REG_AW-1:0] rdaddr_W_o,
    output logic              rdwr_W_o,
    output logic [XLEN-1:0]   datareg_W_o,
    output logic [XLEN-1:0]   inst_W_o,
    output logic [CNT_W-1:0]  retired_o
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t            r_state;
    logic              r_mready;
    logic              r_wvalid;
    logic [REG_AW-1:0] r_rd;
    logic              r_wr;
    logic [XLEN-1:0]   r_data;
    logic [XLEN-1:0]   r_inst;
    logic [CNT_W-1:0]  r_retired;

    logic [REG_AW-1:0] r_skid_rd;
    logic              r_skid_wr;
    logic [XLEN-1:0]   r_skid_data;
    logic [XLEN-1:0]   r_skid_inst;

    logic w_accept;
    logic w_drain;
    logic w_wr_M;
    logic w_skid_load;

    assign w_accept    = m_valid_i & r_mready;
    assign w_drain     = r_wvalid & w_ready_i;
    // Write enable is masked on entry so a write to x0 never leaves the stage.
    assign w_wr_M      = rdwr_M_i & (rdaddr_M_i != '0);
    assign w_skid_load = (r_state == ST_ONE) & w_accept & ~w_drain & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_EMPTY;
            r_mready  <= 1'b1;
            r_wvalid  <= 1'b0;
            r_rd      <= '0;
            r_wr      <= 1'b0;
            r_data    <= '0;
            r_inst    <= NOP_INST;
            r_retired <= '0;
        end else if (flush_i) begin
            r_state  <= ST_EMPTY;
            r_mready <= 1'b1;
            r_wvalid <= 1'b0;
            r_rd     <= '0;
            r_wr     <= 1'b0;
            r_data   <= '0;
            r_inst   <= NOP_INST;
        end else begin
            if (w_drain) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state  <= ST_ONE;
                        r_wvalid <= 1'b1;
                        r_rd     <= rdaddr_M_i;
                        r_wr     <= w_wr_M;
                        r_data   <= datareg_M_i;
                        r_inst   <= inst_M_i;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        r_state  <= ST_TWO;
                        r_mready <= 1'b0;
                    end else if (w_accept && w_drain) begin
                        r_rd   <= rdaddr_M_i;
                        r_wr   <= w_wr_M;
                        r_data <= datareg_M_i;
                        r_inst <= inst_M_i;
                    end else if (w_drain) begin
                        r_state  <= ST_EMPTY;
                        r_wvalid <= 1'b0;
                        r_rd     <= '0;
                        r_wr     <= 1'b0;
                        r_data   <= '0;
                        r_inst   <= NOP_INST;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        r_state  <= ST_ONE;
                        r_mready <= 1'b1;
                        r_rd     <= r_skid_rd;
                        r_wr     <= r_skid_wr;
                        r_data   <= r_skid_data;
                        r_inst   <= r_skid_inst;
                    end
                end
                default: begin
                    r_state  <= ST_EMPTY;
                    r_mready <= 1'b1;
                    r_wvalid <= 1'b0;
                end
            endcase
        end
    end

    // Skid holds data only; its contents are meaningless unless state is TWO.
    always_ff @(posedge clk_i) begin
        if (w_skid_load) begin
            r_skid_rd   <= rdaddr_M_i;
            r_skid_wr   <= w_wr_M;
            r_skid_data <= datareg_M_i;
            r_skid_inst <= inst_M_i;
        end
    end

    assign m_ready_o   = r_mready;
    assign w_valid_o   = r_wvalid;
    assign rdaddr_W_o  = r_rd;
    assign rdwr_W_o    = r_wr;
    assign datareg_W_o = r_data;
    assign inst_W_o    = r_inst;
    assign retired_o   = r_retired;

endmodule

// File: tb/tb_pipe_stage_mw.sv
// Scoreboard bench for pipe_stage_mw: a FIFO-of-entries model fed by the
// driver on accept and consumed by a separate monitor on drain.
module tb_pipe_stage_mw;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] data;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic        m_valid_i;
    logic [4:0]  rdaddr_M_i;
    logic        rdwr_M_i;
    logic [31:0] datareg_M_i;
    logic [31:0] inst_M_i;
    logic        w_ready_i;

    logic        m_ready_o;
    logic        w_valid_o;
    logic [4:0]  rdaddr_W_o;
    logic        rdwr_W_o;
    logic [31:0] datareg_W_o;
    logic [31:0] inst_W_o;
    logic [31:0] retired_o;

    logic        m_ready4;
    logic        w_valid4;
    logic [4:0]  rdaddr4;
    logic        rdwr4;
    logic [31:0] data4;
    logic [31:0] inst4;
    logic [3:0]  retired4;

    ent_t        q[$];
    logic [31:0] model_ret;
    int          n_vec;
    int          n_err;

    pipe_stage_mw #(.XLEN(32), .REG_AW(5), .CNT_W(32), .NOP_INST(NOP)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
        .rdaddr_M_i(rdaddr_M_i), .rdwr_M_i(rdwr_M_i),
        .datareg_M_i(datareg_M_i), .inst_M_i(inst_M_i),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .rdaddr_W_o(rdaddr_W_o), .rdwr_W_o(rdwr_W_o),
        .datareg_W_o(datareg_W_o), .inst_W_o(inst_W_o),
        .retired_o(retired_o)
    );

    pipe_stage_mw #(.XLEN(32), .REG_AW(5), .CNT_W(4), .NOP_INST(NOP)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .m_valid_i(m_valid_i), .m_ready_o(m_ready4),
        .rdaddr_M_i(rdaddr_M_i), .rdwr_M_i(rdwr_M_i),
        .datareg_M_i(datareg_M_i), .inst_M_i(inst_M_i),
        .w_valid_o(w_valid4), .w_ready_i(w_ready_i),
        .rdaddr_W_o(rdaddr4), .rdwr_W_o(rdwr4),
        .datareg_W_o(data4), .inst_W_o(inst4),
        .retired_o(retired4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the entry is recorded only if the handshake completes.
    task automatic cycle(input logic mv, input logic [4:0] rd, input logic wr,
                         input logic [31:0] d, input logic [31:0] in,
                         input logic wrdy, input logic fl, output logic acc);
        @(posedge clk);
        #1;
        m_valid_i   = mv;
        rdaddr_M_i  = rd;
        rdwr_M_i    = wr;
        datareg_M_i = d;
        inst_M_i    = in;
        w_ready_i   = wrdy;
        flush_i     = fl;
        @(negedge clk);
        #1;
        acc = mv && m_ready_o && !fl;
        if (acc) q.push_back('{rd, wr, d, in});
    endtask

    task automatic idle(input logic wrdy);
        logic a;
        cycle(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, wrdy, 1'b0, a);
    endtask

    // Reset is dropped mid-cycle; outputs must already be idle one step later.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni    = 1'b0;
        m_valid_i = 1'b1;
        #1;
        chk("rst_w_valid", {63'd0, w_valid_o}, 64'd0);
        chk("rst_m_ready", {63'd0, m_ready_o}, 64'd1);
        chk("rst_rdwr", {63'd0, rdwr_W_o}, 64'd0);
        chk("rst_rdaddr", {59'd0, rdaddr_W_o}, 64'd0);
        chk("rst_data", {32'd0, datareg_W_o}, 64'd0);
        chk("rst_inst", {32'd0, inst_W_o}, {32'd0, NOP});
        chk("rst_retired", {32'd0, retired_o}, 64'd0);
        q.delete();
        model_ret = 32'd0;
        @(posedge clk);
        #1;
        rst_ni    = 1'b1;
        m_valid_i = 1'b0;
    endtask

    // Monitor: compares the head entry and handshake state mid-cycle.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                chk("w_valid", {63'd0, w_valid_o}, {63'd0, q.size() > 0});
                chk("m_ready", {63'd0, m_ready_o}, {63'd0, q.size() < 2});
                chk("retired", {32'd0, retired_o}, {32'd0, model_ret});
                chk("retired_wrap4", {60'd0, retired4}, {60'd0, model_ret[3:0]});
                if (q.size() == 0) begin
                    chk("idle_rdwr", {63'd0, rdwr_W_o}, 64'd0);
                    chk("idle_rdaddr", {59'd0, rdaddr_W_o}, 64'd0);
                    chk("idle_data", {32'd0, datareg_W_o}, 64'd0);
                    chk("idle_inst", {32'd0, inst_W_o}, {32'd0, NOP});
                end else begin
                    e = q[0];
                    chk("head_rdaddr", {59'd0, rdaddr_W_o}, {59'd0, e.rd});
                    chk("head_rdwr", {63'd0, rdwr_W_o}, {63'd0, e.wr && (e.rd != 5'd0)});
                    chk("head_data", {32'd0, datareg_W_o}, {32'd0, e.data});
                    chk("head_inst", {32'd0, inst_W_o}, {32'd0, e.inst});
                end
                if (flush_i) begin
                    q.delete();
                end else if (q.size() > 0 && w_ready_i) begin
                    void'(q.pop_front());
                    model_ret = model_ret + 32'd1;
                end
            end
        end
    end

    initial begin
        logic acc;
        int   tries;
        n_vec       = 0;
        n_err       = 0;
        model_ret   = 32'd0;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        m_valid_i   = 1'b0;
        rdaddr_M_i  = 5'd0;
        rdwr_M_i    = 1'b0;
        datareg_M_i = 32'd0;
        inst_M_i    = 32'd0;
        w_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Streaming A..D at full rate
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'(i + 1), 1'b1, 32'h10 + 32'(i), 32'h100 + 32'(i), 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b1);
        chk("stream_retired_4", {32'd0, retired_o}, 64'd4);

        // Back-pressure: A, B fill the buffer, C held off then delivered in order
        cycle(1'b1, 5'd5, 1'b1, 32'hA, 32'hA0, 1'b0, 1'b0, acc);
        cycle(1'b1, 5'd6, 1'b1, 32'hB, 32'hB0, 1'b0, 1'b0, acc);
        cycle(1'b1, 5'd7, 1'b1, 32'hC, 32'hC0, 1'b0, 1'b0, acc);
        chk("bp_C_refused", {63'd0, acc}, 64'd0);
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 8) begin
            cycle(1'b1, 5'd7, 1'b1, 32'hC, 32'hC0, 1'b1, 1'b0, acc);
            tries++;
        end
        chk("bp_C_accepted", {63'd0, acc}, 64'd1);
        repeat (4) idle(1'b1);

        // Flush in state TWO while offering E
        cycle(1'b1, 5'd8, 1'b1, 32'h1, 32'h11, 1'b0, 1'b0, acc);
        cycle(1'b1, 5'd9, 1'b1, 32'h2, 32'h22, 1'b0, 1'b0, acc);
        cycle(1'b1, 5'd10, 1'b1, 32'hE, 32'hEE, 1'b1, 1'b1, acc);
        idle(1'b0);
        chk("flush_inst_nop", {32'd0, inst_W_o}, {32'd0, NOP});

        // x0 write suppression
        cycle(1'b1, 5'd0, 1'b1, 32'hDEADBEEF, 32'h33, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("x0_rdwr", {63'd0, rdwr_W_o}, 64'd0);
        chk("x0_data", {32'd0, datareg_W_o}, 64'hDEADBEEF);
        idle(1'b1);

        // Counter wrap with CNT_W=4
        do_reset();
        for (int i = 0; i < 17; i++)
            cycle(1'b1, 5'(i), 1'b1, 32'(i), 32'(i * 3), 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b1);
        chk("wrap_17_drains", {60'd0, retired4}, 64'd1);

        // Async reset in state TWO, then the first entry after release
        cycle(1'b1, 5'd1, 1'b1, 32'h51, 32'h510, 1'b0, 1'b0, acc);
        cycle(1'b1, 5'd2, 1'b1, 32'h52, 32'h520, 1'b0, 1'b0, acc);
        do_reset();
        cycle(1'b1, 5'd3, 1'b1, 32'h53, 32'h530, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("post_reset_first", {32'd0, datareg_W_o}, 64'h53);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            cycle(($urandom % 4) != 0,
                  (($urandom % 4) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom), $urandom, $urandom,
                  ($urandom % 3) != 0, ($urandom % 40) == 0, acc);
        end
        repeat (4) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
